latch: RTL and testbench



---
 rtl/latch.sv | 30 +++
 tb/tb_latch.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/latch.sv
// Level-sensitive D latch with asynchronous active-low reset.
// Transparency polarity, width and reset value are parameters, so one cell serves every latch use.
module latch #(
    parameter int unsigned           WIDTH            = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE      = '0,
    parameter bit                    TRANSPARENT_HIGH = 1'b1
) (
    input  logic             CK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic             is_open;
    logic [WIDTH-1:0] q_q;

    assign is_open = (CK == TRANSPARENT_HIGH);

    // Reset dominates; while open Q tracks D, otherwise the storage node holds.
    always_latch begin
        if (!RST_N) begin
            q_q <= RESET_VALUE;
        end else if (is_open) begin
            q_q <= D;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_latch.sv
// Randomized bench for the latch: three instances (8-bit high-transparent, 8-bit
// low-transparent, 1-bit default) compared against a behavioural model.
module tb_latch;

    logic       CK;
    logic       RST_N;
    logic [7:0] D8;
    logic       D1;
    logic [7:0] q_hi;
    logic [7:0] q_lo;
    logic       q_one;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0] m_hi;
    logic [7:0] m_lo;
    logic       m_one;

    latch #(
        .WIDTH            (8),
        .RESET_VALUE      (8'hA5),
        .TRANSPARENT_HIGH (1'b1)
    ) u_hi (
        .CK    (CK),
        .RST_N (RST_N),
        .D     (D8),
        .Q     (q_hi)
    );

    latch #(
        .WIDTH            (8),
        .RESET_VALUE      (8'h5A),
        .TRANSPARENT_HIGH (1'b0)
    ) u_lo (
        .CK    (CK),
        .RST_N (RST_N),
        .D     (D8),
        .Q     (q_lo)
    );

    latch u_one (
        .CK    (CK),
        .RST_N (RST_N),
        .D     (D1),
        .Q     (q_one)
    );

    initial begin
        CK = 1'b1;
        forever #50 CK = ~CK;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected storage value from the observable rules: reset forces the reset
    // value, an open latch shows D, a closed latch shows what it last showed.
    function automatic logic [7:0] expect_q(input logic [7:0] prev, input logic rst_n,
                                            input logic open, input logic [7:0] d,
                                            input logic [7:0] rv);
        if (!rst_n) return rv;
        return open ? d : prev;
    endfunction

    task automatic eval_and_check(input string tag);
        m_hi  = expect_q(m_hi, RST_N, CK == 1'b1, D8, 8'hA5);
        m_lo  = expect_q(m_lo, RST_N, CK == 1'b0, D8, 8'h5A);
        m_one = expect_q({7'b0, m_one}, RST_N, CK == 1'b1, {7'b0, D1}, 8'h00) != 8'h00;
        check({tag, "_hi"},  q_hi,  m_hi);
        check({tag, "_lo"},  q_lo,  m_lo);
        check({tag, "_one"}, {7'b0, q_one}, {7'b0, m_one});
    endtask

    task automatic new_data();
        D8 = 8'($urandom);
        D1 = 1'($urandom);
    endtask

    initial begin
        m_hi  = '0;
        m_lo  = '0;
        m_one = 1'b0;
        RST_N = 1'b0;
        D8    = 8'h3C;
        D1    = 1'b0;

        // Reset held through the first part of the high phase.
        #1;
        check("reset_hi",  q_hi,  8'hA5);
        check("reset_lo",  q_lo,  8'h5A);
        check("reset_one", {7'b0, q_one}, 8'h00);
        eval_and_check("reset");

        // Release while high: high-transparent copy picks up D at once.
        #29 RST_N = 1'b1;
        #1;
        check("release_hi", q_hi, 8'h3C);
        check("release_lo", q_lo, 8'h5A);
        eval_and_check("release");

        // Low phase: D change ignored by the high-transparent copy.
        #29 D8 = 8'hFF;
        #1;
        check("opaque_hi", q_hi, 8'h3C);
        check("open_lo",   q_lo, 8'hFF);
        eval_and_check("lowphase");

        for (int i = 0; i < 300; i++) begin
            @(CK);
            #1;
            eval_and_check("edge");
            #9;
            case ($urandom_range(0, 3))
                0: begin
                    RST_N = 1'b0;
                    #1 eval_and_check("rst_on");
                    #9 RST_N = 1'b1;
                    #1 eval_and_check("rst_off");
                    #9;
                end
                1, 2: begin
                    new_data();
                    #1 eval_and_check("d_early");
                    #19;
                end
                default: begin
                    #20;
                end
            endcase
            new_data();
            #1 eval_and_check("d_late");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout at t=%0t: got running expected finished", $time);
        $fatal(1, "timeout");
    end

endmodule
